otbn_insn_prefetch_queue: RTL and testbench

// Multi-entry instruction prefetch queue between IMEM and the OTBN controller's fetch stage.

---
 rtl/otbn_insn_prefetch_queue_pkg.sv | 31 +++
 rtl/otbn_insn_prefetch_queue_issue.sv | 94 +++++++++
 rtl/otbn_insn_prefetch_queue.sv | 159 +++++++++++++++
 tb/tb_otbn_insn_prefetch_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otbn_insn_prefetch_queue_pkg.sv
// Shared types and constants for the OTBN instruction prefetch queue.
// Entries hold a zero-extended address plus the raw integrity-protected IMEM word.
package otbn_insn_prefetch_queue_pkg;

    localparam int unsigned InsnWidth    = 39;
    localparam int unsigned MaxAddrWidth = 32;

    localparam logic [6:0] OpcodeBranch = 7'h63;
    localparam logic [6:0] OpcodeJal    = 7'h6f;
    localparam logic [6:0] OpcodeJalr   = 7'h67;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BR_WAIT   = 2'd1,
        LOOP_WAIT = 2'd2
    } prefetch_state_e;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [InsnWidth-1:0]    data;
    } prefetch_entry_t;

    function automatic int unsigned vbits(int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic logic is_branch(logic [6:0] opcode);
        return (opcode == OpcodeBranch) || (opcode == OpcodeJal) || (opcode == OpcodeJalr);
    endfunction

endpackage

// File: rtl/otbn_insn_prefetch_queue_issue.sv
// Prefetch issue unit: next-issue address, branch stall and hardware-loop redirect FSM.
// Combinational issue decision; redirect overrides prefetch_en; no issue while a branch is pending.
module otbn_insn_prefetch_queue_issue
    import otbn_insn_prefetch_queue_pkg::*;
#(
    parameter int unsigned ImemSizeByte  = 4096,
    parameter int unsigned ImemAddrWidth = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush,
    input  logic                     prefetch_en,
    input  logic                     room,
    input  logic                     redirect,
    input  logic [ImemAddrWidth-1:0] redirect_addr,
    input  logic                     branch_seen,
    input  logic                     branch_popped,
    input  logic                     loop_end_popped,
    input  logic                     loop_active,
    input  logic [31:0]              loop_iterations,
    input  logic [ImemAddrWidth:0]   loop_end_addr,
    input  logic [ImemAddrWidth-1:0] loop_jump_addr,
    output logic                     issue_vld,
    output logic [ImemAddrWidth-1:0] issue_addr
);

    prefetch_state_e           state_q, state_d;
    logic [ImemAddrWidth-1:0]  nxt_q, nxt_d, nxt_seq;
    logic [ImemAddrWidth:0]    addr_plus4;
    logic                      loop_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nxt_q <= '0;
        end else begin
            nxt_q <= nxt_d;
        end
    end

    // A word that is itself a branch stops issue the cycle it returns, so nothing past it is fetched.
    always_comb begin
        issue_vld  = 1'b0;
        issue_addr = nxt_q;
        if (!flush) begin
            if (redirect) begin
                issue_vld  = 1'b1;
                issue_addr = redirect_addr;
            end else if (state_q != BR_WAIT && !branch_seen && prefetch_en && room) begin
                issue_vld = 1'b1;
            end
        end
    end

    assign addr_plus4 = {1'b0, issue_addr} + (ImemAddrWidth+1)'(4);
    assign nxt_seq    = (addr_plus4 >= (ImemAddrWidth+1)'(ImemSizeByte)) ? '0
                                                                        : addr_plus4[ImemAddrWidth-1:0];

    assign loop_hit = issue_vld && loop_active && (loop_iterations > 32'd1) &&
                      ({1'b0, issue_addr} == loop_end_addr) &&
                      (redirect || state_q != LOOP_WAIT);

    always_comb begin
        nxt_d = nxt_q;
        if (issue_vld) begin
            nxt_d = loop_hit ? loop_jump_addr : nxt_seq;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else if (redirect) begin
            state_d = loop_hit ? LOOP_WAIT : RUN;
        end else if (branch_seen && !branch_popped) begin
            state_d = BR_WAIT;
        end else if (state_q == BR_WAIT && branch_popped) begin
            state_d = RUN;
        end else if (loop_hit) begin
            state_d = LOOP_WAIT;
        end else if (state_q == LOOP_WAIT && loop_end_popped) begin
            state_d = RUN;
        end
    end

endmodule

// File: rtl/otbn_insn_prefetch_queue.sv
// Multi-entry IMEM prefetch queue feeding the OTBN fetch stage.
// Hit latency 1 (ready comb, resp registered); miss/empty re-issue gives ready one cycle later.
// Issue stalls when occupancy + in-flight reaches Depth; fetch waits on ready until the head matches.
module otbn_insn_prefetch_queue
    import otbn_insn_prefetch_queue_pkg::*;
#(
    parameter int unsigned ImemSizeByte = 4096,
    parameter int unsigned Depth        = 2,
    localparam int unsigned ImemAddrWidth = vbits(ImemSizeByte),
    localparam int unsigned DepthW        = vbits(Depth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic                     imem_req_o,
    output logic [ImemAddrWidth-1:0] imem_addr_o,
    input  logic [38:0]              imem_rdata_i,
    input  logic                     imem_rvalid_i,
    input  logic                     prefetch_en_i,
    input  logic                     flush_i,
    input  logic                     fetch_req_valid_i,
    input  logic [ImemAddrWidth-1:0] fetch_req_addr_i,
    output logic                     fetch_req_ready_o,
    output logic                     fetch_resp_valid_o,
    output logic [ImemAddrWidth-1:0] fetch_resp_addr_o,
    output logic [38:0]              fetch_resp_data_o,
    input  logic                     fetch_resp_clear_i,
    input  logic                     loop_active_i,
    input  logic [31:0]              loop_iterations_i,
    input  logic [ImemAddrWidth:0]   loop_end_addr_i,
    input  logic [ImemAddrWidth-1:0] loop_jump_addr_i,
    output logic                     fetch_miss_o,
    output logic [DepthW-1:0]        occupancy_o
);

    localparam int unsigned AW   = ImemAddrWidth;
    localparam int unsigned PtrW = vbits(Depth);

    prefetch_entry_t      entry_q [Depth];
    logic [PtrW-1:0]      head_q, tail_q;
    logic [DepthW-1:0]    count_q;
    logic                 inflight_q;
    logic [AW-1:0]        inflight_addr_q;

    logic                 rsp_live, head_vld, head_match;
    logic                 hit, bypass, miss, reissue, redirect;
    logic                 push, push_store, pop, room;
    logic [InsnWidth-1:0] pop_data;
    logic                 issue_vld;
    logic [AW-1:0]        issue_addr;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // Read data is only trusted when it answers the read issued last cycle and nothing killed it.
    assign rsp_live   = imem_rvalid_i & inflight_q & ~flush_i;
    assign head_vld   = (count_q != '0);
    assign head_match = (entry_q[head_q].addr == MaxAddrWidth'(fetch_req_addr_i));

    assign hit      = fetch_req_valid_i & head_vld & head_match & ~flush_i;
    assign bypass   = fetch_req_valid_i & ~head_vld & rsp_live & (inflight_addr_q == fetch_req_addr_i);
    assign miss     = fetch_req_valid_i & head_vld & ~head_match & ~flush_i;
    assign reissue  = fetch_req_valid_i & ~head_vld & ~bypass & ~flush_i;
    assign redirect = miss | reissue;

    assign push       = rsp_live & ~redirect;
    assign push_store = push & ~bypass;
    assign pop        = hit | bypass;
    assign pop_data   = bypass ? imem_rdata_i : entry_q[head_q].data;
    assign room       = ({1'b0, count_q} + {{DepthW{1'b0}}, inflight_q}) < (DepthW+1)'(Depth);

    otbn_insn_prefetch_queue_issue #(
        .ImemSizeByte  (ImemSizeByte),
        .ImemAddrWidth (AW)
    ) u_issue (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush           (flush_i),
        .prefetch_en     (prefetch_en_i),
        .room            (room),
        .redirect        (redirect),
        .redirect_addr   (fetch_req_addr_i),
        .branch_seen     (push & is_branch(imem_rdata_i[6:0])),
        .branch_popped   (pop & is_branch(pop_data[6:0])),
        .loop_end_popped (pop & ({1'b0, fetch_req_addr_i} == loop_end_addr_i)),
        .loop_active     (loop_active_i),
        .loop_iterations (loop_iterations_i),
        .loop_end_addr   (loop_end_addr_i),
        .loop_jump_addr  (loop_jump_addr_i),
        .issue_vld       (issue_vld),
        .issue_addr      (issue_addr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q      <= issue_vld;
            inflight_addr_q <= issue_addr;
            if (flush_i || redirect) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_store) begin
                    tail_q <= ptr_inc(tail_q);
                end
                if (hit) begin
                    head_q <= ptr_inc(head_q);
                end
                if (push_store && !hit) begin
                    count_q <= count_q + DepthW'(1);
                end else if (!push_store && hit) begin
                    count_q <= count_q - DepthW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                entry_q[i] <= '0;
            end
        end else if (push_store) begin
            entry_q[tail_q] <= {MaxAddrWidth'(inflight_addr_q), imem_rdata_i};
        end
    end

    // A transfer beats a simultaneous clear; flush beats both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_resp_valid_o <= 1'b0;
            fetch_resp_addr_o  <= '0;
            fetch_resp_data_o  <= '0;
        end else if (flush_i) begin
            fetch_resp_valid_o <= 1'b0;
            fetch_resp_addr_o  <= '0;
            fetch_resp_data_o  <= '0;
        end else if (pop) begin
            fetch_resp_valid_o <= 1'b1;
            fetch_resp_addr_o  <= fetch_req_addr_i;
            fetch_resp_data_o  <= pop_data;
        end else if (fetch_resp_clear_i) begin
            fetch_resp_valid_o <= 1'b0;
        end
    end

    assign imem_req_o        = issue_vld;
    assign imem_addr_o       = issue_addr;
    assign fetch_req_ready_o = pop;
    assign fetch_miss_o      = miss;
    assign occupancy_o       = count_q;

endmodule

// File: tb/tb_otbn_insn_prefetch_queue.sv
// Directed bench for the prefetch queue with a one-cycle IMEM model.
module tb_otbn_insn_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [38:0] imem_rdata;
    logic        imem_rvalid = 1'b0;
    logic        prefetch_en = 1'b0;
    logic        flush = 1'b0;
    logic        req_vld = 1'b0;
    logic [11:0] req_addr = '0;
    logic        req_rdy;
    logic        resp_vld;
    logic [11:0] resp_addr;
    logic [38:0] resp_dat;
    logic        resp_clear = 1'b0;
    logic        loop_active = 1'b0;
    logic [31:0] loop_iter = '0;
    logic [12:0] loop_end = '0;
    logic [11:0] loop_jump = '0;
    logic        miss;
    logic [1:0]  occupancy;
    logic        br_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [11:0] lreq  [4] = '{12'h018, 12'h018, 12'h01C, 12'h020};
    logic [11:0] lexp3 [4] = '{12'h018, 12'h01C, 12'h020, 12'h018};
    logic [11:0] lexp1 [4] = '{12'h018, 12'h01C, 12'h020, 12'h024};

    always #5 clk = ~clk;

    otbn_insn_prefetch_queue #(
        .ImemSizeByte (4096),
        .Depth        (2)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .imem_req_o         (imem_req),
        .imem_addr_o        (imem_addr),
        .imem_rdata_i       (imem_rdata),
        .imem_rvalid_i      (imem_rvalid),
        .prefetch_en_i      (prefetch_en),
        .flush_i            (flush),
        .fetch_req_valid_i  (req_vld),
        .fetch_req_addr_i   (req_addr),
        .fetch_req_ready_o  (req_rdy),
        .fetch_resp_valid_o (resp_vld),
        .fetch_resp_addr_o  (resp_addr),
        .fetch_resp_data_o  (resp_dat),
        .fetch_resp_clear_i (resp_clear),
        .loop_active_i      (loop_active),
        .loop_iterations_i  (loop_iter),
        .loop_end_addr_i    (loop_end),
        .loop_jump_addr_i   (loop_jump),
        .fetch_miss_o       (miss),
        .occupancy_o        (occupancy)
    );

    function automatic logic [38:0] mem_word(input logic [11:0] a);
        if (br_en && a == 12'h010) return {7'h55, 8'h00, a, 5'h00, 7'h63};
        return {7'h2a, 8'h00, a, 5'h00, 7'h13};
    endfunction

    // IMEM answers one cycle after each request; deliberately not reset so stale data can appear.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   64'(imem_req),  64'd0);
        check("rst_addr",  64'(imem_addr), 64'd0);
        check("rst_rdy",   64'(req_rdy),   64'd0);
        check("rst_rvld",  64'(resp_vld),  64'd0);
        check("rst_rdat",  64'(resp_dat),  64'd0);
        check("rst_miss",  64'(miss),      64'd0);
        check("rst_occ",   64'(occupancy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line hits
        @(negedge clk);
        prefetch_en = 1'b1; req_vld = 1'b1; req_addr = 12'h000;
        #1;
        check("s_req0",  64'(imem_req),  64'd1);
        check("s_addr0", 64'(imem_addr), 64'h000);
        check("s_rdy0",  64'(req_rdy),   64'd0);
        check("s_miss0", 64'(miss),      64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_addr = 12'(4 * k);
            #1;
            check("s_rdy",   64'(req_rdy),   64'd1);
            check("s_issue", 64'(imem_addr), 64'(4 * k + 4));
            if (k > 0) begin
                check("s_raddr", 64'(resp_addr), 64'(4 * (k - 1)));
                check("s_rdat",  64'(resp_dat),  64'(mem_word(12'(4 * (k - 1)))));
            end
        end
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        check("s_rvld",  64'(resp_vld),  64'd1);
        check("s_raddr", 64'(resp_addr), 64'h008);
        repeat (2) @(negedge clk);
        #1;
        check("s_occ2",  64'(occupancy), 64'd2);
        check("s_full",  64'(imem_req),  64'd0);
        resp_clear = 1'b1;
        @(negedge clk);
        resp_clear = 1'b0;
        #1;
        check("clr_rvld", 64'(resp_vld), 64'd0);

        // Miss on a full queue
        @(negedge clk);
        req_vld = 1'b1; req_addr = 12'h030;
        #1;
        check("m_miss", 64'(miss),      64'd1);
        check("m_req",  64'(imem_req),  64'd1);
        check("m_addr", 64'(imem_addr), 64'h030);
        check("m_rdy0", 64'(req_rdy),   64'd0);
        @(negedge clk);
        resp_clear = 1'b1;
        #1;
        check("m_occ",   64'(occupancy), 64'd0);
        check("m_rdy1",  64'(req_rdy),   64'd1);
        check("m_miss1", 64'(miss),      64'd0);
        @(negedge clk);
        resp_clear = 1'b0; req_vld = 1'b0; prefetch_en = 1'b0;
        #1;
        check("m_rvld",  64'(resp_vld),  64'd1);
        check("m_raddr", 64'(resp_addr), 64'h030);
        check("m_rdat",  64'(resp_dat),  64'(mem_word(12'h030)));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("f_occ", 64'(occupancy), 64'd0);

        // Branch at 0x10 stalls issue until it pops
        br_en = 1'b1;
        @(negedge clk);
        prefetch_en = 1'b1; req_vld = 1'b1; req_addr = 12'h00C;
        #1;
        check("b_addr0", 64'(imem_addr), 64'h00C);
        @(negedge clk);
        #1;
        check("b_rdy0",  64'(req_rdy),   64'd1);
        check("b_issue", 64'(imem_addr), 64'h010);
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        check("b_stall0", 64'(imem_req), 64'd0);
        @(negedge clk);
        #1;
        check("b_stall1", 64'(imem_req),  64'd0);
        check("b_occ",    64'(occupancy), 64'd1);
        @(negedge clk);
        req_vld = 1'b1; req_addr = 12'h010;
        #1;
        check("b_rdy1",   64'(req_rdy),  64'd1);
        check("b_stall2", 64'(imem_req), 64'd0);
        @(negedge clk);
        req_addr = 12'h040;
        #1;
        check("b_treq",  64'(imem_req),  64'd1);
        check("b_taddr", 64'(imem_addr), 64'h040);
        check("b_miss",  64'(miss),      64'd0);
        check("b_raddr", 64'(resp_addr), 64'h010);
        check("b_rdat",  64'(resp_dat),  64'(mem_word(12'h010)));
        @(negedge clk);
        #1;
        check("b_rdy2", 64'(req_rdy), 64'd1);
        @(negedge clk);
        req_vld = 1'b0; prefetch_en = 1'b0; flush = 1'b1; br_en = 1'b0;

        // Hardware loop: iterations 3 redirects, iterations 1 falls through
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            flush = 1'b0; loop_active = 1'b1; loop_end = 13'h020; loop_jump = 12'h018;
            loop_iter = (r == 0) ? 32'd3 : 32'd1;
            prefetch_en = 1'b1; req_vld = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                req_addr = lreq[k];
                #1;
                check("l_rdy",   64'(req_rdy),  64'(k > 0));
                check("l_req",   64'(imem_req), 64'd1);
                check("l_issue", 64'(imem_addr), 64'((r == 0) ? lexp3[k] : lexp1[k]));
            end
            @(negedge clk);
            req_vld = 1'b0; prefetch_en = 1'b0; flush = 1'b1;
        end

        // Address wrap, then flush against a simultaneous hit and clear
        @(negedge clk);
        flush = 1'b0; loop_active = 1'b0;
        prefetch_en = 1'b1; req_vld = 1'b1; req_addr = 12'hFFC;
        #1;
        check("w_addr0", 64'(imem_addr), 64'hFFC);
        @(negedge clk);
        #1;
        check("w_rdy",  64'(req_rdy),   64'd1);
        check("w_wrap", 64'(imem_addr), 64'h000);
        @(negedge clk);
        flush = 1'b1; resp_clear = 1'b1; req_addr = 12'h000; prefetch_en = 1'b0;
        #1;
        check("fl_rdy",  64'(req_rdy),  64'd0);
        check("fl_req",  64'(imem_req), 64'd0);
        check("fl_rvld", 64'(resp_vld), 64'd1);
        @(negedge clk);
        flush = 1'b0; resp_clear = 1'b0; req_vld = 1'b0;
        #1;
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_rvld0", 64'(resp_vld),  64'd0);
        check("fl_raddr", 64'(resp_addr), 64'd0);
        @(negedge clk);
        #1;
        check("fl_stale", 64'(occupancy), 64'd0);

        // Asynchronous reset with a read in flight
        @(negedge clk);
        prefetch_en = 1'b1; req_vld = 1'b1; req_addr = 12'h100;
        #1;
        check("r_addr0", 64'(imem_addr), 64'h100);
        @(negedge clk);
        #1;
        check("r_rdy", 64'(req_rdy), 64'd1);
        @(negedge clk);
        req_vld = 1'b0;
        @(negedge clk);
        #1;
        check("r_occ1", 64'(occupancy), 64'd1);
        check("r_rvld", 64'(resp_vld),  64'd1);
        #2;
        rst_n = 1'b0; prefetch_en = 1'b0;
        #1;
        check("ar_req",   64'(imem_req),  64'd0);
        check("ar_addr",  64'(imem_addr), 64'd0);
        check("ar_rdy",   64'(req_rdy),   64'd0);
        check("ar_rvld",  64'(resp_vld),  64'd0);
        check("ar_raddr", 64'(resp_addr), 64'd0);
        check("ar_rdat",  64'(resp_dat),  64'd0);
        check("ar_miss",  64'(miss),      64'd0);
        check("ar_occ",   64'(occupancy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("ar_stale", 64'(occupancy), 64'd0);
        check("ar_rvld1", 64'(resp_vld),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
